// File: rtl/rbz_spi_reg_master_if.sv
// rbz_spi_reg_master_if
// Wishbone classic slave-side bus bundle for rbz_spi_reg_master.
// Signal names follow the Caravel wbs_* naming so the wrapper hookup is obvious.
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : cycle controls (master -> slave)
//   wbs_sel_i[3:0]                  : byte selects
//   wbs_adr_i[31:0]                 : byte address
//   wbs_dat_i[31:0]                 : write data
//   wbs_ack_o                       : single-cycle acknowledge (slave -> master)
//   wbs_dat_o[31:0]                 : read data, 0 when not acking
interface rbz_spi_reg_master_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rbz_spi_reg_master.sv
// rbz_spi_reg_master
// Wishbone-slave SPI initiator for the raybox-zero register SPI port.
// A write to DATA serialises DATA[FRAME_BITS-1:0] MSB-first, SPI mode 0,
// with half-period H = div+1 clocks.
// Ports:
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   wb (slave modport)     : Wishbone classic register bus
//   o_reg_sclk/csb/mosi    : registered SPI outputs
//   o_vec_csb              : vec-port chip select (only with RBZ_SPI_VEC_PORT_EN)
//   o_busy                 : high from frame accept until end of the csb-high gap
// Optional feature macro: RBZ_SPI_VEC_PORT_EN (offset 0xC writes target vec csb).
module rbz_spi_reg_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FRAME_BITS = 28,
  parameter logic [7:0]  DIV_RESET  = 8'd1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  rbz_spi_reg_master_if.slave        wb,
  output logic                       o_reg_sclk,
  output logic                       o_reg_csb,
  output logic                       o_reg_mosi,
`ifdef RBZ_SPI_VEC_PORT_EN
  output logic                       o_vec_csb,
`endif
  output logic                       o_busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t                state_reg, state_next;
  logic [7:0]            div_reg, div_lat_reg;
  logic [7:0]            h_cnt_reg, h_cnt_next;
  logic [5:0]            bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] sr_reg, sr_next;
  logic                  ack_reg;
  logic [31:0]           dat_reg;
  logic                  sclk_reg, csb_reg, mosi_reg, busy_reg;
  logic                  sclk_next, csb_next, mosi_next, busy_next, active_next;
`ifdef RBZ_SPI_VEC_PORT_EN
  logic                  vec_sel_reg, vec_sel_next, vec_csb_reg, vec_csb_next;
`endif

  // Bus decode
  logic        hit, req, tick, can_accept, vec_wr, data_wr, accept, ack_next;
  logic [1:0]  off;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign hit = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // The !ack_reg term keeps ack to a single cycle when stb is held.
  assign req = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_reg;
  assign off = wb.wbs_adr_i[3:2];
  assign tick = (h_cnt_reg == 8'd0);
  // Accepting in the last GAP cycle gives back-to-back frames exactly H clocks of csb high.
  assign can_accept = (state_reg == IDLE) || ((state_reg == GAP) && tick);
`ifdef RBZ_SPI_VEC_PORT_EN
  assign vec_wr = req & wb.wbs_we_i & (off == 2'd3);
`else
  assign vec_wr = 1'b0;
`endif
  assign data_wr = (req & wb.wbs_we_i & (off == 2'd0)) | vec_wr;
  assign accept = data_wr & can_accept;
  // A frame-start write that cannot be accepted yet is stalled by withholding ack.
  assign ack_next = req & (~data_wr | can_accept);
  assign unused_ok = &{1'b0, wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i};

  always_comb begin
    rd_data = 32'd0;
    case (off)
      2'd1:    rd_data = {31'd0, busy_reg};
      2'd2:    rd_data = {24'd0, div_reg};
      default: rd_data = 32'd0;
    endcase
  end

  // FSM next-state and next-output logic
  always_comb begin
    state_next   = state_reg;
    h_cnt_next   = tick ? 8'd0 : h_cnt_reg - 8'd1;
    bit_cnt_next = bit_cnt_reg;
    sr_next      = sr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = SETUP;
          h_cnt_next   = div_reg;
          bit_cnt_next = 6'(FRAME_BITS);
          sr_next      = wb.wbs_dat_i[FRAME_BITS-1:0];
        end
      end
      SETUP: begin
        if (tick) begin
          state_next = SHIFT_HI;
          h_cnt_next = div_lat_reg;
        end
      end
      SHIFT_HI: begin
        // Falling sclk: present the next bit and count this one as sent.
        if (tick) begin
          state_next   = SHIFT_LO;
          h_cnt_next   = div_lat_reg;
          sr_next      = sr_reg << 1;
          bit_cnt_next = bit_cnt_reg - 6'd1;
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          state_next = (bit_cnt_reg == 6'd0) ? HOLD : SHIFT_HI;
          h_cnt_next = div_lat_reg;
        end
      end
      HOLD: begin
        if (tick) begin
          state_next = GAP;
          h_cnt_next = div_lat_reg;
        end
      end
      GAP: begin
        if (tick) begin
          if (accept) begin
            state_next   = SETUP;
            h_cnt_next   = div_reg;
            bit_cnt_next = 6'(FRAME_BITS);
            sr_next      = wb.wbs_dat_i[FRAME_BITS-1:0];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    active_next = (state_next == SETUP) || (state_next == SHIFT_HI) ||
                  (state_next == SHIFT_LO) || (state_next == HOLD);
    sclk_next   = (state_next == SHIFT_HI);
    mosi_next   = active_next & sr_next[FRAME_BITS-1];
    busy_next   = (state_next != IDLE);
`ifdef RBZ_SPI_VEC_PORT_EN
    vec_sel_next = accept ? vec_wr : vec_sel_reg;
    csb_next     = ~(active_next & ~vec_sel_next);
    vec_csb_next = ~(active_next & vec_sel_next);
`else
    csb_next     = ~active_next;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      h_cnt_reg   <= 8'd0;
      bit_cnt_reg <= 6'd0;
      sr_reg      <= '0;
      div_reg     <= DIV_RESET;
      div_lat_reg <= DIV_RESET;
      ack_reg     <= 1'b0;
      dat_reg     <= 32'd0;
      sclk_reg    <= 1'b0;
      csb_reg     <= 1'b1;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef RBZ_SPI_VEC_PORT_EN
      vec_sel_reg <= 1'b0;
      vec_csb_reg <= 1'b1;
`endif
    end else begin
      state_reg   <= state_next;
      h_cnt_reg   <= h_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      sr_reg      <= sr_next;
      ack_reg     <= ack_next;
      dat_reg     <= (ack_next & ~wb.wbs_we_i) ? rd_data : 32'd0;
      if (req & wb.wbs_we_i & (off == 2'd2) & wb.wbs_sel_i[0])
        div_reg <= wb.wbs_dat_i[7:0];
      // Divider is frozen per frame so CTRL writes mid-frame apply to the next one.
      if (accept)
        div_lat_reg <= div_reg;
      sclk_reg    <= sclk_next;
      csb_reg     <= csb_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
`ifdef RBZ_SPI_VEC_PORT_EN
      vec_sel_reg <= vec_sel_next;
      vec_csb_reg <= vec_csb_next;
`endif
    end
  end

  assign wb.wbs_ack_o = ack_reg;
  assign wb.wbs_dat_o = dat_reg;
  assign o_reg_sclk   = sclk_reg;
  assign o_reg_csb    = csb_reg;
  assign o_reg_mosi   = mosi_reg;
  assign o_busy       = busy_reg;
`ifdef RBZ_SPI_VEC_PORT_EN
  assign o_vec_csb    = vec_csb_reg;
`endif

endmodule

// File: tb/tb_rbz_spi_reg_master.sv
// tb_rbz_spi_reg_master
// Self-checking bench for rbz_spi_reg_master: table of register accesses plus
// hand-written frame sequences observed through an SPI waveform monitor.
module tb_rbz_spi_reg_master;
  localparam logic [31:0] B = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, csb, mosi, busy;
`ifdef RBZ_SPI_VEC_PORT_EN
  logic vec_csb;
`endif

  rbz_spi_reg_master_if wb ();

  rbz_spi_reg_master dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
    .o_reg_sclk (sclk),
    .o_reg_csb  (csb),
    .o_reg_mosi (mosi),
`ifdef RBZ_SPI_VEC_PORT_EN
    .o_vec_csb  (vec_csb),
`endif
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  // ---------------- SPI monitor (samples on negedge) ----------------
  logic        csb_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;
  int          low_len, high_len, run_len, nbits, busy_len, frame_cnt;
  int          hi_min, hi_max, lo_min, lo_max;
  int          last_low_len, last_gap_len, last_bits, last_busy_len;
  int          last_hi_min, last_hi_max, last_lo_min, last_lo_max;
  logic [31:0] cap, last_cap;

  always @(negedge clk) begin
    csb_prev  <= csb;
    sclk_prev <= sclk;
    busy_prev <= busy;
    if (csb === 1'b0) begin
      if (csb_prev) begin
        low_len <= 1; nbits <= 0; cap <= 32'd0; run_len <= 1;
        last_gap_len <= high_len;
        hi_min <= 255; hi_max <= 0; lo_min <= 255; lo_max <= 0;
      end else begin
        low_len <= low_len + 1;
        if (sclk != sclk_prev) begin
          run_len <= 1;
          if (sclk) begin
            cap    <= {cap[30:0], mosi};
            nbits  <= nbits + 1;
            lo_min <= (run_len < lo_min) ? run_len : lo_min;
            lo_max <= (run_len > lo_max) ? run_len : lo_max;
          end else begin
            hi_min <= (run_len < hi_min) ? run_len : hi_min;
            hi_max <= (run_len > hi_max) ? run_len : hi_max;
          end
        end else begin
          run_len <= run_len + 1;
        end
      end
    end else begin
      if (!csb_prev) begin
        last_low_len <= low_len; last_bits <= nbits; last_cap <= cap;
        last_hi_min <= hi_min; last_hi_max <= hi_max;
        last_lo_min <= lo_min; last_lo_max <= lo_max;
        frame_cnt <= frame_cnt + 1;
        high_len <= 1;
      end else begin
        high_len <= high_len + 1;
      end
    end
    if (busy === 1'b1) busy_len <= busy_prev ? busy_len + 1 : 1;
    else if (busy_prev) last_busy_len <= busy_len;
  end

  // ---------------- bus helpers ----------------
  task automatic bus_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int budget,
                            output logic acked, output logic [31:0] rdata, output int waited);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    acked = 1'b0; rdata = 32'd0; waited = 0;
    while (!acked && waited < budget) begin
      @(posedge clk); @(negedge clk);
      waited++;
      if (wb.wbs_ack_o) begin acked = 1'b1; rdata = wb.wbs_dat_o; end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(posedge clk); @(negedge clk); n++; end
    if (busy !== 1'b0) begin errors++; checks++; $display("FAIL %s: timeout busy=%b want 0", nm, busy); end
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic        a;
    logic [31:0] r;
    int          w, fc, stall_acks, late;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic [31:0] r;
    int          w, fc, stall_acks, late;

    tbl[0]  = '{"rd_ctrl_reset",       1'b0, B + 32'h8, 32'd0,         4'hF,    1'b1, 32'd1};
    tbl[1]  = '{"rd_status_idle",      1'b0, B + 32'h4, 32'd0,         4'hF,    1'b1, 32'd0};
    tbl[2]  = '{"rd_data_reg",         1'b0, B + 32'h0, 32'd0,         4'hF,    1'b1, 32'd0};
    tbl[3]  = '{"rd_reserved_c",       1'b0, B + 32'hC, 32'd0,         4'hF,    1'b1, 32'd0};
    tbl[4]  = '{"rd_outside_hi",       1'b0, 32'h3000_0010, 32'd0,     4'hF,    1'b0, 32'd0};
    tbl[5]  = '{"wr_outside_ctrl",     1'b1, 32'h3000_0108, 32'h55,    4'hF,    1'b0, 32'd0};
    tbl[6]  = '{"rd_ctrl_after_out",   1'b0, B + 32'h8, 32'd0,         4'hF,    1'b1, 32'd1};
    tbl[7]  = '{"wr_ctrl_sel_no_b0",   1'b1, B + 32'h8, 32'hFFFF_FF05, 4'b1110, 1'b1, 32'd0};
    tbl[8]  = '{"rd_ctrl_after_sel",   1'b0, B + 32'h8, 32'd0,         4'hF,    1'b1, 32'd1};
    tbl[9]  = '{"wr_ctrl_div0",        1'b1, B + 32'h8, 32'hFFFF_FF00, 4'hF,    1'b1, 32'd0};
    tbl[10] = '{"rd_ctrl_div0",        1'b0, B + 32'h8, 32'd0,         4'hF,    1'b1, 32'd0};
    tbl[11] = '{"rd_outside_lo",       1'b0, 32'h2000_0008, 32'd0,     4'hF,    1'b0, 32'd0};

    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'd0; wb.wbs_dat_i = 32'd0; wb.wbs_sel_i = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_csb", {31'd0, csb}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven register accesses (FSM idle)
    for (int i = 0; i < 12; i++) begin
      bus_access(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, 3, a, r, w);
      chk({tbl[i].name, "_ack"}, {31'd0, (a && w == 1)}, {31'd0, tbl[i].exp_ack});
      chk({tbl[i].name, "_dat"}, r, tbl[i].exp_dat);
      @(negedge clk);
    end

    // Ack lasts one cycle even with stb held
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = B + 32'h8;
    @(posedge clk); @(negedge clk);
    chk("hold_ack_first", {31'd0, wb.wbs_ack_o}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("hold_ack_second", {31'd0, wb.wbs_ack_o}, 32'd0);
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    @(negedge clk);

    // A: div=0, 28-bit frame
    fc = frame_cnt;
    bus_access(1'b1, B, 32'h0ABC_DEF1, 4'hF, 5, a, r, w);
    chk("A_ack_latency", {31'd0, (a && w == 1)}, 32'd1);
    chk("A_csb_at_ack", {31'd0, csb}, 32'd0);
    chk("A_busy_at_ack", {31'd0, busy}, 32'd1);
    wait_idle("A_done", 200);
    chk("A_frames", frame_cnt, fc + 1);
    chk("A_csb_low_len", last_low_len, 58);
    chk("A_bits", last_bits, 28);
    chk("A_data", last_cap, 32'h0ABC_DEF1);
    chk("A_busy_len", last_busy_len, 59);

    // B: div=3, DATA=1; STATUS read mid-frame is not stalled
    bus_access(1'b1, B + 32'h8, 32'h3, 4'hF, 3, a, r, w);
    bus_access(1'b1, B, 32'h1, 4'hF, 5, a, r, w);
    repeat (5) @(negedge clk);
    bus_access(1'b0, B + 32'h4, 32'd0, 4'hF, 3, a, r, w);
    chk("B_status_busy_ack", {31'd0, (a && w == 1)}, 32'd1);
    chk("B_status_busy", r, 32'd1);
    wait_idle("B_done", 500);
    chk("B_csb_low_len", last_low_len, 232);
    chk("B_bits", last_bits, 28);
    chk("B_data", last_cap, 32'h1);
    chk("B_sclk_hi_min", last_hi_min, 4);
    chk("B_sclk_hi_max", last_hi_max, 4);
    chk("B_sclk_lo_min", last_lo_min, 4);
    chk("B_sclk_lo_max", last_lo_max, 4);
    chk("B_busy_len", last_busy_len, 236);

    // C: back-to-back frames, second write stalls until end of GAP
    fc = frame_cnt;
    bus_access(1'b1, B, 32'h0012_3456, 4'hF, 5, a, r, w);
    bus_access(1'b1, B, 32'h0FED_CBA9, 4'hF, 400, a, r, w);
    chk("C_stall_acked", {31'd0, a}, 32'd1);
    chk("C_stall_wait", w, 236);
    chk("C_frame1_data", last_cap, 32'h0012_3456);
    chk("C_frame1_len", last_low_len, 232);
    wait_idle("C_done", 600);
    chk("C_frames", frame_cnt, fc + 2);
    chk("C_frame2_data", last_cap, 32'h0FED_CBA9);
    chk("C_gap_len", last_gap_len, 4);

    // D: reset at bit 10
    bus_access(1'b1, B, 32'h0FFF_FFFF, 4'hF, 5, a, r, w);
    w = 0;
    while (nbits < 10 && w < 300) begin @(posedge clk); @(negedge clk); w++; end
    chk("D_reached_bit10", {31'd0, (nbits >= 10)}, 32'd1);
    chk("D_mosi_before", {31'd0, mosi}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("D_csb", {31'd0, csb}, 32'd1);
    chk("D_sclk", {31'd0, sclk}, 32'd0);
    chk("D_mosi", {31'd0, mosi}, 32'd0);
    chk("D_busy", {31'd0, busy}, 32'd0);
    chk("D_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_access(1'b0, B + 32'h4, 32'd0, 4'hF, 3, a, r, w);
    chk("D_status", r, 32'd0);
    bus_access(1'b0, B + 32'h8, 32'd0, 4'hF, 3, a, r, w);
    chk("D_ctrl", r, 32'd1);

    // E: stalled DATA write abandoned by dropping cyc (H=2 after reset)
    fc = frame_cnt;
    bus_access(1'b1, B, 32'h0000_00AA, 4'hF, 5, a, r, w);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = B; wb.wbs_dat_i = 32'h0555_5555;
    stall_acks = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (wb.wbs_ack_o) stall_acks++; end
    wb.wbs_cyc_i = 1'b0;
    @(posedge clk); @(negedge clk);
    if (wb.wbs_ack_o) stall_acks++;
    wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    chk("E_no_stall_ack", stall_acks, 0);
    wait_idle("E_done", 300);
    late = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (busy !== 1'b0 || csb !== 1'b1 || wb.wbs_ack_o !== 1'b0) late++;
    end
    chk("E_no_second_frame", late, 0);
    chk("E_frames", frame_cnt, fc + 1);
    chk("E_data", last_cap, 32'hAA);

`ifdef RBZ_SPI_VEC_PORT_EN
    // Vec port: offset 0xC frame drives vec csb only
    bus_access(1'b1, B + 32'hC, 32'h5, 4'hF, 5, a, r, w);
    chk("V_ack", {31'd0, (a && w == 1)}, 32'd1);
    begin
      int vec_low = 0, reg_low = 0, n = 0;
      while (busy === 1'b1 && n < 300) begin
        if (vec_csb === 1'b0) vec_low++;
        if (csb === 1'b0) reg_low++;
        @(posedge clk); @(negedge clk); n++;
      end
      chk("V_vec_low", vec_low, 2 * 58);
      chk("V_reg_low", reg_low, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rbz_spi_reg_master.md
# rbz_spi_reg_master

Wishbone-slave SPI initiator that drives the raybox-zero register SPI port (`reg_sclk`/`reg_csb`/`reg_mosi`) from the Caravel management core. It replaces bit-banging those pins through the logic analyser. Firmware writes one frame word over Wishbone, and the block serialises it MSB-first in SPI mode 0. The block sits in `user_project_wrapper` between the Wishbone bus and the `i_reg_*` inputs of `top_ew_algofoogle`.

## Interface
Parameters:
- `BASE_ADDR`, `32'h3000_0000`: block base address; decode on `wbs_adr_i[31:4]`.
- `FRAME_BITS`, `28`: bits shifted per frame, 1..32; taken from `DATA[FRAME_BITS-1:0]`.
- `DIV_RESET`, `8'd1`: reset value of `CTRL.div`.

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic cycle controls.
- `wbs_sel_i` in 4: byte selects, honoured for CTRL only.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data; 0 when not acking.
- `o_reg_sclk`, `o_reg_csb`, `o_reg_mosi` out 1 each: SPI to raybox, all registered.
- `o_busy` out 1: high from frame accept until the end of GAP.

## Operation
- Register map, offset `adr[3:2]`:
  - 0x0 DATA (W): starts a frame. Reads return 0.
  - 0x4 STATUS (R): bit0 = busy.
  - 0x8 CTRL (R/W): bits[7:0] = `div`. Other bits read 0.
  - 0xC: reads 0, writes ignored, still acked.
- Access outside the `BASE_ADDR` window: no ack, no side effect.
- Half-period H = `div`+1 clocks, range 1..256. `div` and DATA are latched at frame accept, so CTRL writes during a frame apply to the next frame.
- FSM states and transitions:
  - IDLE: csb=1, sclk=0, mosi=0.
  - SETUP: csb=0, mosi=MSB, sclk=0 for H clocks.
  - SHIFT: per bit, sclk=1 for H clocks then sclk=0 for H clocks. mosi changes only on the sclk falling edge, to the next bit.
  - HOLD: csb=0, sclk=0 for H clocks.
  - GAP: csb=1 for H clocks, then back to IDLE.
- Bit counter: counts FRAME_BITS down to 0. After the last low phase the FSM goes to HOLD.
- DATA write while busy: ack withheld (bus stall) until the FSM reaches IDLE, then accepted that cycle. If `wbs_cyc_i` drops while stalled, the request is abandoned and no frame starts.
- Reads and CTRL writes are never stalled, including while busy.
- Reset (any time, including mid-frame): the cycle after `wb_rst_i` is sampled high, csb=1, sclk=0, mosi=0, `o_busy`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `div`=DIV_RESET, FSM=IDLE. The partial frame is dropped and a pending stalled request is not acked.

## Timing
- Ack is registered. A request with stb&cyc at cycle N (not stalled) gets `wbs_ack_o`=1 at N+1 for exactly one cycle, then deasserts even if stb is held. Read data is valid with ack.
- A DATA write acked at N+1: csb falls at N+1, `o_busy`=1 at N+1.
- Frame length, csb low: H·(2·FRAME_BITS+2) clocks.
- Total busy time: H·(2·FRAME_BITS+3) clocks.
- Raybox samples mosi on sclk rising edge. Required margins: setup ≥ H clocks and hold ≥ H clocks.
- Back-to-back frames: minimum csb-high gap is H clocks.

## Configuration
- `RBZ_SPI_VEC_PORT_EN` defined:
  - Adds output `o_vec_csb` and shares sclk/mosi with the vec SPI port.
  - DATA writes to offset 0x0 select reg csb. Writes to offset 0xC select vec csb; 0xC reads still return 0.
  - The unselected csb stays 1 throughout.
  - `o_vec_csb` resets to 1.
- Undefined: no `o_vec_csb` port; offset 0xC behaves as reserved.

## Test plan
- div=0, FRAME_BITS=28, write DATA=0x0ABCDEF1 -> ack 1 cycle later. csb low for exactly 58 clocks. 28 rising edges sample bits 0xABCDEF1 MSB-first. `o_busy` high for 59 clocks.
- Write CTRL=0x03, then DATA=0x0000_0001 -> H=4: sclk high/low phases of 4 clocks, csb low 232 clocks, last sampled bit 1, all earlier bits 0.
- Two DATA writes back-to-back -> second ack stalled until IDLE. Second frame starts with csb high for exactly H clocks between frames, and both frames are intact.
- Assert `wb_rst_i` for 1 cycle at bit 10 of a frame -> next cycle csb=1, sclk=0, mosi=0, busy=0. A STATUS read afterwards returns 0 and a CTRL read returns `DIV_RESET`.
- Stalled DATA write with `wbs_cyc_i` dropped mid-stall -> no ack and no second frame. Read of 0xC and of an address outside the window -> 0xC returns 0 with ack; outside the window gets no ack.
- With `RBZ_SPI_VEC_PORT_EN`, write 0xC=0x5 -> `o_vec_csb` toggles low while `o_reg_csb` stays 1.
